// File: rtl/pipe_latch_pkg.sv
// Shared widths, control-bit positions and occupancy encoding for pipe_stage_latch.
package pipe_latch_pkg;

    localparam int unsigned DEF_INSN_W = 19;
    localparam int unsigned DEF_DATA_W = 32;
    localparam int unsigned DEF_NWORDS = 4;
    localparam int unsigned DEF_CTRL_W = 8;
    localparam int unsigned DEF_CNT_W  = 16;

    // Bit positions inside the ctrl field
    localparam int unsigned CTRL_WE      = 0;
    localparam int unsigned CTRL_RWD     = 1;
    localparam int unsigned CTRL_DMWE    = 2;
    localparam int unsigned CTRL_JAL     = 3;
    localparam int unsigned CTRL_RD30    = 4;
    localparam int unsigned CTRL_RD31    = 5;
    localparam int unsigned CTRL_WTTOREG = 6;
    localparam int unsigned CTRL_MATHEXC = 7;

    // Occupancy is {skid.valid, main.valid}; 2'b10 is unreachable
    typedef enum logic [1:0] {
        OCC_EMPTY = 2'b00,
        OCC_ONE   = 2'b01,
        OCC_FULL  = 2'b11
    } occ_state_e;

endpackage

// File: rtl/pipe_entry.sv
// One latch entry: valid bit updated every cycle, payload captured on load, sync clear.
module pipe_entry #(
    parameter int unsigned INSN_W  = 19,
    parameter int unsigned WORDS_W = 128,
    parameter int unsigned CTRL_W  = 8
) (
    input  logic               clk,
    input  logic               clr,
    input  logic               load,
    input  logic               valid_next,
    input  logic [INSN_W-1:0]  insn_next,
    input  logic [WORDS_W-1:0] words_next,
    input  logic [CTRL_W-1:0]  ctrl_next,
    output logic               valid,
    output logic [INSN_W-1:0]  insn,
    output logic [WORDS_W-1:0] words,
    output logic [CTRL_W-1:0]  ctrl
);

    // Entry storage; payload only moves when load is asserted
    always_ff @(posedge clk) begin
        if (clr) begin
            valid <= 1'b0;
            insn  <= '0;
            words <= '0;
            ctrl  <= '0;
        end else begin
            valid <= valid_next;
            if (load) begin
                insn  <= insn_next;
                words <= words_next;
                ctrl  <= ctrl_next;
            end
        end
    end

endmodule

// File: rtl/pipe_stage_latch.sv
// Inter-stage pipeline latch with valid/ready handshake, 2-entry skid, flush and bubble counter.
module pipe_stage_latch
    import pipe_latch_pkg::*;
#(
    parameter int unsigned INSN_W = DEF_INSN_W,
    parameter int unsigned DATA_W = DEF_DATA_W,
    parameter int unsigned NWORDS = DEF_NWORDS,
    parameter int unsigned CTRL_W = DEF_CTRL_W,
    parameter int unsigned CNT_W  = DEF_CNT_W
) (
    input  logic                     clk,
    input  logic                     clr,
    input  logic                     flush,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [INSN_W-1:0]        in_insn,
    input  logic [NWORDS*DATA_W-1:0] in_words,
    input  logic [CTRL_W-1:0]        in_ctrl,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [INSN_W-1:0]        out_insn,
    output logic [NWORDS*DATA_W-1:0] out_words,
    output logic [CTRL_W-1:0]        out_ctrl,
    output logic [CNT_W-1:0]         bubble_cnt
);

    localparam int unsigned WORDS_W = NWORDS * DATA_W;

    logic               m_valid, s_valid;
    logic [INSN_W-1:0]  m_insn, s_insn;
    logic [WORDS_W-1:0] m_words, s_words;
    logic [CTRL_W-1:0]  m_ctrl, s_ctrl;

    logic               m_load, s_load, m_from_skid;
    logic               m_valid_next, s_valid_next;
    logic [INSN_W-1:0]  m_insn_next;
    logic [WORDS_W-1:0] m_words_next;
    logic [CTRL_W-1:0]  m_ctrl_next;

    logic       in_fire, out_fire;
    occ_state_e state;

    assign state    = occ_state_e'({s_valid, m_valid});
    assign in_ready = ~s_valid;
    assign in_fire  = in_valid & in_ready;
    assign out_fire = m_valid & out_ready;

    // Next occupancy and entry load controls; flush kills everything including this cycle's input
    always_comb begin
        m_load       = 1'b0;
        s_load       = 1'b0;
        m_from_skid  = 1'b0;
        m_valid_next = m_valid;
        s_valid_next = s_valid;
        if (flush) begin
            m_valid_next = 1'b0;
            s_valid_next = 1'b0;
        end else begin
            case (state)
                OCC_EMPTY: begin
                    if (in_fire) begin
                        m_load       = 1'b1;
                        m_valid_next = 1'b1;
                    end
                end
                OCC_ONE: begin
                    if (out_fire && in_fire) begin
                        m_load = 1'b1;
                    end else if (out_fire) begin
                        m_valid_next = 1'b0;
                    end else if (in_fire) begin
                        s_load       = 1'b1;
                        s_valid_next = 1'b1;
                    end
                end
                OCC_FULL: begin
                    if (out_fire) begin
                        m_load       = 1'b1;
                        m_from_skid  = 1'b1;
                        s_valid_next = 1'b0;
                    end
                end
                default: begin
                    m_valid_next = 1'b0;
                    s_valid_next = 1'b0;
                end
            endcase
        end
    end

    // Main entry refills from skid first so ordering stays FIFO
    always_comb begin
        m_insn_next  = in_insn;
        m_words_next = in_words;
        m_ctrl_next  = in_ctrl;
        if (m_from_skid) begin
            m_insn_next  = s_insn;
            m_words_next = s_words;
            m_ctrl_next  = s_ctrl;
        end
    end

    pipe_entry #(
        .INSN_W (INSN_W),
        .WORDS_W(WORDS_W),
        .CTRL_W (CTRL_W)
    ) u_main (
        .clk       (clk),
        .clr       (clr),
        .load      (m_load),
        .valid_next(m_valid_next),
        .insn_next (m_insn_next),
        .words_next(m_words_next),
        .ctrl_next (m_ctrl_next),
        .valid     (m_valid),
        .insn      (m_insn),
        .words     (m_words),
        .ctrl      (m_ctrl)
    );

    pipe_entry #(
        .INSN_W (INSN_W),
        .WORDS_W(WORDS_W),
        .CTRL_W (CTRL_W)
    ) u_skid (
        .clk       (clk),
        .clr       (clr),
        .load      (s_load),
        .valid_next(s_valid_next),
        .insn_next (in_insn),
        .words_next(in_words),
        .ctrl_next (in_ctrl),
        .valid     (s_valid),
        .insn      (s_insn),
        .words     (s_words),
        .ctrl      (s_ctrl)
    );

    // Saturating count of cycles where downstream was ready but nothing was offered
    always_ff @(posedge clk) begin
        if (clr) begin
            bubble_cnt <= '0;
        end else if (out_ready && !m_valid && (bubble_cnt != {CNT_W{1'b1}})) begin
            bubble_cnt <= bubble_cnt + CNT_W'(1);
        end
    end

    assign out_valid = m_valid;
    assign out_insn  = m_insn;
    assign out_words = m_words;
    // A bubble must never present live control bits downstream
    assign out_ctrl  = m_valid ? m_ctrl : '0;

endmodule

// File: tb/tb_pipe_stage_latch.sv
// Directed bench for pipe_stage_latch: reset, streaming, backpressure, flush, bubble count, simultaneous fire.
module tb_pipe_stage_latch;
    import pipe_latch_pkg::*;

    localparam int unsigned INSN_W = 19;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned NWORDS = 4;
    localparam int unsigned CTRL_W = 8;
    localparam int unsigned CNT_W  = 4;
    localparam int unsigned WW     = NWORDS * DATA_W;

    logic              clk = 1'b0;
    logic              clr, flush, in_valid, in_ready, out_valid, out_ready;
    logic [INSN_W-1:0] in_insn, out_insn;
    logic [WW-1:0]     in_words, out_words;
    logic [CTRL_W-1:0] in_ctrl, out_ctrl;
    logic [CNT_W-1:0]  bubble_cnt;

    int total = 0;
    int bad   = 0;

    pipe_stage_latch #(
        .INSN_W(INSN_W), .DATA_W(DATA_W), .NWORDS(NWORDS), .CTRL_W(CTRL_W), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .clr(clr), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_insn(in_insn),
        .in_words(in_words), .in_ctrl(in_ctrl),
        .out_valid(out_valid), .out_ready(out_ready), .out_insn(out_insn),
        .out_words(out_words), .out_ctrl(out_ctrl), .bubble_cnt(bubble_cnt)
    );

    always #5 clk = ~clk;

    // Word k = v + k, so word ordering mistakes are visible
    function automatic logic [WW-1:0] mk_words(input logic [31:0] v);
        return {v + 32'd3, v + 32'd2, v + 32'd1, v};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic offer(input logic [31:0] v, input logic [CTRL_W-1:0] c);
        in_valid = 1'b1;
        in_words = mk_words(v);
        in_insn  = INSN_W'(v);
        in_ctrl  = c;
    endtask

    task automatic test_reset();
        clr = 1'b1; flush = 1'b0; out_ready = 1'b0;
        in_valid = 1'b1; in_ctrl = 8'hFF; in_words = mk_words(32'hDEAD0000); in_insn = 19'h7FFFF;
        step(); step();
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        total++; if (out_ctrl !== 8'h00) begin bad++; $display("FAIL reset_out_ctrl got=%h exp=00", out_ctrl); end
        total++; if (out_words !== '0) begin bad++; $display("FAIL reset_out_words got=%h exp=0", out_words); end
        total++; if (out_insn !== '0) begin bad++; $display("FAIL reset_out_insn got=%h exp=0", out_insn); end
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
        total++; if (bubble_cnt !== 4'd0) begin bad++; $display("FAIL reset_bubble got=%0d exp=0", bubble_cnt); end
        clr = 1'b0; in_valid = 1'b0; in_ctrl = '0;
        step();
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL post_reset_out_valid got=%b exp=0", out_valid); end
    endtask

    task automatic test_stream();
        out_ready = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            offer(32'(i), CTRL_W'(i));
            step();
            total++; if (out_valid !== 1'b1 || out_words !== mk_words(32'(i)))
                begin bad++; $display("FAIL stream_word%0d got v=%b w=%h exp w=%h", i, out_valid, out_words, mk_words(32'(i))); end
            total++; if (out_ctrl !== CTRL_W'(i) || out_insn !== INSN_W'(i))
                begin bad++; $display("FAIL stream_ctrl%0d got c=%h i=%h exp %0d", i, out_ctrl, out_insn, i); end
            total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL stream_ready%0d got=%b exp=1", i, in_ready); end
        end
        in_valid = 1'b0;
        step();
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL stream_drain got=%b exp=0", out_valid); end
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        offer(32'h100, 8'h01);
        step();
        total++; if (out_words !== mk_words(32'h100) || in_ready !== 1'b1)
            begin bad++; $display("FAIL bp_a_loaded got w=%h r=%b exp A,1", out_words, in_ready); end
        offer(32'h200, 8'h02);
        step();
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL bp_full_ready got=%b exp=0", in_ready); end
        offer(32'h300, 8'h03);
        step();
        total++; if (in_ready !== 1'b0 || out_words !== mk_words(32'h100))
            begin bad++; $display("FAIL bp_hold got r=%b w=%h exp 0,A", in_ready, out_words); end
        out_ready = 1'b1;
        step();
        total++; if (out_valid !== 1'b1 || out_words !== mk_words(32'h200) || out_ctrl !== 8'h02)
            begin bad++; $display("FAIL bp_b_next got w=%h c=%h exp B", out_words, out_ctrl); end
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL bp_ready_back got=%b exp=1", in_ready); end
        step();
        total++; if (out_valid !== 1'b1 || out_words !== mk_words(32'h300))
            begin bad++; $display("FAIL bp_c_next got w=%h exp C", out_words); end
        in_valid = 1'b0;
        step();
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL bp_drain got=%b exp=0", out_valid); end
    endtask

    task automatic test_flush();
        out_ready = 1'b0;
        offer(32'h400, 8'h05); step();
        offer(32'h500, 8'h05); step();
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL flush_prefill got=%b exp=0", in_ready); end
        offer(32'h600, 8'h05);
        flush = 1'b1;
        step();
        total++; if (out_valid !== 1'b0 || out_ctrl !== 8'h00 || in_ready !== 1'b1)
            begin bad++; $display("FAIL flush_full got v=%b c=%h r=%b exp 0,00,1", out_valid, out_ctrl, in_ready); end
        total++; if (out_ctrl[CTRL_WE] !== 1'b0 || out_ctrl[CTRL_DMWE] !== 1'b0)
            begin bad++; $display("FAIL flush_we_dmwe got=%h exp=00", out_ctrl); end
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        step(); step();
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL flush_no_ghost got=%b exp=0", out_valid); end
        // flush in ONE with an accepted input: both dropped
        out_ready = 1'b0;
        offer(32'h700, 8'h01); step();
        offer(32'h800, 8'h05); flush = 1'b1;
        step();
        flush = 1'b0; in_valid = 1'b0;
        total++; if (out_valid !== 1'b0 || out_ctrl !== 8'h00)
            begin bad++; $display("FAIL flush_one got v=%b c=%h exp 0,00", out_valid, out_ctrl); end
        out_ready = 1'b1;
        step();
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL flush_input_dropped got=%b exp=0", out_valid); end
    endtask

    task automatic test_clr_mid();
        out_ready = 1'b0;
        offer(32'h900, 8'h01); step();
        offer(32'hA00, 8'h01); step();
        offer(32'hB00, 8'hFF); clr = 1'b1;
        step();
        clr = 1'b0; in_valid = 1'b0;
        total++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_words !== '0)
            begin bad++; $display("FAIL clr_mid got v=%b r=%b w=%h exp 0,1,0", out_valid, in_ready, out_words); end
    endtask

    task automatic test_bubble();
        out_ready = 1'b0; in_valid = 1'b0; clr = 1'b1;
        step();
        clr = 1'b0; out_ready = 1'b1;
        for (int i = 0; i < 5; i++) step();
        total++; if (bubble_cnt !== 4'd5) begin bad++; $display("FAIL bubble_5 got=%0d exp=5", bubble_cnt); end
        for (int i = 0; i < 15; i++) step();
        total++; if (bubble_cnt !== 4'd15) begin bad++; $display("FAIL bubble_sat got=%0d exp=15", bubble_cnt); end
        flush = 1'b1;
        step();
        flush = 1'b0;
        total++; if (bubble_cnt !== 4'd15) begin bad++; $display("FAIL bubble_flush got=%0d exp=15", bubble_cnt); end
        clr = 1'b1;
        step();
        clr = 1'b0; out_ready = 1'b0;
        total++; if (bubble_cnt !== 4'd0) begin bad++; $display("FAIL bubble_clr got=%0d exp=0", bubble_cnt); end
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b1;
        offer(32'hC00, 8'h01); step();
        total++; if (out_words !== mk_words(32'hC00)) begin bad++; $display("FAIL b2b_first got=%h exp E", out_words); end
        offer(32'hD00, 8'h02); step();
        total++; if (out_valid !== 1'b1 || out_words !== mk_words(32'hD00) || out_ctrl !== 8'h02)
            begin bad++; $display("FAIL b2b_second got w=%h c=%h exp F", out_words, out_ctrl); end
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL b2b_no_skid got=%b exp=1", in_ready); end
        in_valid = 1'b0; out_ready = 1'b0;
        step();
        total++; if (out_words !== mk_words(32'hD00)) begin bad++; $display("FAIL b2b_hold got=%h exp F", out_words); end
        out_ready = 1'b1;
        step();
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL b2b_empty got=%b exp=0", out_valid); end
    endtask

    initial begin
        flush = 1'b0; out_ready = 1'b0; clr = 1'b1;
        in_valid = 1'b0; in_insn = '0; in_words = '0; in_ctrl = '0;
        test_reset();
        test_stream();
        test_backpressure();
        test_flush();
        test_clr_mid();
        test_bubble();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
